// File: rtl/uart_mm_responder.sv
// Avalon-MM responder exposing a two-register UART-style interface (data, control/status).
// Every transfer takes a fixed IDLE -> BUSY -> ACK sequence; RX and TX bytes pass through FIFOs.
module uart_mm_responder #(
  parameter int RX_DEPTH = 64,
  parameter int TX_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        address,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = RX_DEPTH[RX_AW:0];
  localparam logic [TX_AW:0] TX_FULL = TX_DEPTH[TX_AW:0];

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t state, state_next;

  logic             req, busy;
  logic             addr_p0, rd_p0;
  logic [7:0]       wbyte_p0;
  logic [2:0]       wctl_p0;
  logic             re, we, txovf;
  logic             unused_wd;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_push, rx_pop, rx_nonempty;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_push, tx_pop, tx_full, tx_ovf_set, ctl_wr;

  logic [31:0]      wspace32;
  logic             ri, wi;
  logic [31:0]      data_word, ctl_word;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    if (v > 32'h0000_FFFF) return 16'hFFFF;
    return v[15:0];
  endfunction

  assign unused_wd = ^{writedata[31:11], writedata[9:2]};

  assign req         = chipselect & (~read_n | ~write_n);
  assign busy        = (state == BUSY);
  assign waitrequest = (state != ACK);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture: both strobes low resolves to a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p0 <= 1'b0;
      rd_p0   <= 1'b0;
    end else if (state == IDLE && req) begin
      addr_p0 <= address;
      rd_p0   <= ~read_n;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      wbyte_p0 <= writedata[7:0];
      wctl_p0  <= {writedata[10], writedata[1:0]};
    end
  end

  assign rx_nonempty = (rx_count != '0);
  assign rx_ready    = (rx_count != RX_FULL);
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = busy & rd_p0 & ~addr_p0 & rx_nonempty;

  assign tx_full     = (tx_count == TX_FULL);
  assign tx_valid    = (tx_count != '0);
  assign tx_data     = tx_mem[tx_rptr];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push     = busy & ~rd_p0 & ~addr_p0 & ~tx_full;
  assign tx_ovf_set  = busy & ~rd_p0 & ~addr_p0 & tx_full;
  assign ctl_wr      = busy & ~rd_p0 & addr_p0;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
    if (tx_push) tx_mem[tx_wptr] <= wbyte_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      re    <= 1'b0;
      we    <= 1'b0;
      txovf <= 1'b0;
    end else begin
      if (ctl_wr) begin
        re <= wctl_p0[0];
        we <= wctl_p0[1];
        if (wctl_p0[2]) txovf <= 1'b0;
      end
      if (tx_ovf_set) txovf <= 1'b1;
    end
  end

  assign wspace32  = 32'(TX_DEPTH) - 32'(tx_count);
  assign ri        = re & rx_nonempty;
  assign wi        = we & (wspace32 != 32'd0);
  // RAVAIL reports the occupancy left once this read's pop has taken effect.
  assign data_word = {sat16(32'(rx_count) - 32'd1), 1'b1, 7'b0, rx_mem[rx_rptr]};
  assign ctl_word  = {sat16(wspace32), rx_nonempty, 4'b0, txovf, wi, ri, 6'b0, we, re};

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= ri | wi;
      if (busy) begin
        if (!rd_p0)          readdata <= '0;
        else if (addr_p0)    readdata <= ctl_word;
        else if (rx_nonempty) readdata <= data_word;
        else                 readdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_mm_responder.sv
// Directed bench for uart_mm_responder: register reads/writes, RX/TX FIFO flow, overflow, irq, reset abort.
module tb_uart_mm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, address, read_n, write_n;
  logic [31:0] writedata, readdata;
  logic        waitrequest;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [7:0] txq[$];

  uart_mm_responder #(.RX_DEPTH(64), .TX_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && tx_valid && tx_ready) txq.push_back(tx_data);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic bus(input logic a, input logic rd, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic rdy_ack);
    int waits;
    waits = 0;
    chipselect = 1'b1; address = a; read_n = ~rd; write_n = rd; writedata = wd;
    while (waitrequest === 1'b1 && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    rdata = readdata;
    rdy_ack = rx_ready;
    chk("waitcycles", 32'(waits), 32'd2);
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic rd_chk(input logic a, input string tag, input logic [31:0] exp);
    logic [31:0] r;
    logic        k;
    bus(a, 1'b1, 32'd0, r, k);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic a, input logic [31:0] wd);
    logic [31:0] r;
    logic        k;
    bus(a, 1'b0, wd, r, k);
  endtask

  initial begin
    string       msg;
    logic [31:0] r;
    logic        rdy;

    msg = "Handshake recibido\n";
    reset = 1'b1; chipselect = 1'b0; address = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = '0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_waitrequest", 32'(waitrequest), 32'd1);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    rd_chk(1'b1, "ctl_after_reset", 32'h0040_0000);

    rx_valid = 1'b1;
    rx_data = 8'h41; @(posedge clk); #1;
    rx_data = 8'h42; @(posedge clk); #1;
    rx_data = 8'h43; @(posedge clk); #1;
    rx_valid = 1'b0;
    rd_chk(1'b1, "ctl_rvalid", 32'h0040_8000);
    rd_chk(1'b0, "data_rd0", 32'h0002_8041);
    rd_chk(1'b0, "data_rd1", 32'h0001_8042);
    rd_chk(1'b0, "data_rd2", 32'h0000_8043);
    rd_chk(1'b0, "data_rd_empty", 32'h0000_0000);

    tx_ready = 1'b1;
    txq.delete();
    for (int i = 0; i < 19; i++) wr(1'b0, {24'd0, msg[i]});
    repeat (5) @(posedge clk); #1;
    chk("tx_msg_count", 32'(txq.size()), 32'd19);
    for (int i = 0; i < 19; i++) chk("tx_msg_byte", {24'd0, txq[i]}, {24'd0, msg[i]});

    tx_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    txq.delete();
    for (int i = 0; i < 64; i++) wr(1'b0, 32'(i));
    chk("tx_valid_full", 32'(tx_valid), 32'd1);
    rd_chk(1'b1, "ctl_wspace0", 32'h0000_0000);
    wr(1'b0, 32'h0000_00AA);
    rd_chk(1'b1, "ctl_txovf_set", 32'h0000_0400);
    wr(1'b1, 32'h0000_0400);
    rd_chk(1'b1, "ctl_txovf_clr", 32'h0000_0000);
    tx_ready = 1'b1;
    repeat (80) @(posedge clk); #1;
    chk("tx_drain_count", 32'(txq.size()), 32'd64);
    for (int i = 0; i < 64; i++) chk("tx_drain_byte", {24'd0, txq[i]}, 32'(i));
    rd_chk(1'b1, "ctl_tx_empty", 32'h0040_0000);

    rx_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rx_data = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    rx_data = 8'hEE;
    chk("rx_full_ready", 32'(rx_ready), 32'd0);
    bus(1'b0, 1'b1, 32'd0, r, rdy);
    rx_valid = 1'b0;
    chk("rx_full_pop", r, 32'h003F_8080);
    chk("rx_ready_after_pop", 32'(rdy), 32'd1);
    chk("rx_refilled", 32'(rx_ready), 32'd0);
    rd_chk(1'b0, "rx_next_pop", 32'h003F_8081);

    wr(1'b1, 32'h0000_0001);
    @(posedge clk); #1;
    chk("irq_rx_set", 32'(irq), 32'd1);
    rd_chk(1'b1, "ctl_re_ri", 32'h0040_8101);
    for (int k = 0; k < 63; k++)
      rd_chk(1'b0, "rx_drain", {16'(62 - k), 1'b1, 7'b0, (k < 62) ? 8'(8'h82 + k) : 8'hEE});
    @(posedge clk); #1;
    chk("irq_rx_clr", 32'(irq), 32'd0);

    tx_ready = 1'b0;
    wr(1'b0, 32'h0000_0055);
    rx_valid = 1'b1; rx_data = 8'h77; @(posedge clk); #1;
    rx_valid = 1'b0;
    wr(1'b1, 32'h0000_0001);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    chipselect = 1'b1; address = 1'b0; read_n = 1'b0;
    @(posedge clk); #1;
    chk("busy_waitrequest", 32'(waitrequest), 32'd1);
    reset = 1'b1; chipselect = 1'b0; read_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_no_ack", 32'(waitrequest), 32'd1);
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_rx_ready", 32'(rx_ready), 32'd1);
    chk("abort_irq", 32'(irq), 32'd0);
    chk("abort_readdata", readdata, 32'd0);
    rd_chk(1'b1, "abort_ctl", 32'h0040_0000);
    rd_chk(1'b0, "abort_rx_empty", 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
